sample_dumper: RTL

- Read-side counterpart of the capture sampler: after a capture completes, reads the sample RAM back in chronological order and streams every byte over the UART transmitter.
- Unwraps the circular buffer using the trigger offset the sampler latched.
- Sits between the sample RAM read port and uart_tx; started by the top-level control FSM once the sampler has reported done.

---
 rtl/sampler_pkg.sv | 28 ++
 rtl/tx_byte_handshake.sv | 65 ++++++
 rtl/sample_dumper.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sampler_pkg.sv
// Shared types and constants for the capture sampler and its read-back dumper.
package sampler_pkg;

    localparam int DEFAULT_SAMPLE_DEPTH = 8;

    localparam logic [7:0] SYNC_BYTE  = 8'h55;
    localparam logic [7:0] FRAME_BYTE = 8'hAA;

    typedef enum logic [3:0] {
        IDLE,
        HEADER,
        FETCH,
        LATCH,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE,
        TRAILER,
        DONE
    } dump_state_t;

    typedef enum logic [1:0] {
        PH_HDR0,
        PH_HDR1,
        PH_DATA,
        PH_TRAIL
    } frame_phase_t;

endpackage

// File: rtl/tx_byte_handshake.sv
// Drives one byte through uart_tx: waits for idle, pulses tx_start, then follows busy back to idle.
// Handshake: req_i is held high by the owner until ack_o (a single-cycle strobe) is seen; tx_data must stay valid meanwhile.
module tx_byte_handshake
    import sampler_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        tx_active_i,
    output logic        tx_start_o,
    output logic        ack_o,
    output dump_state_t state_o
);

    // A transmitter that never raises busy is released after four cycles.
    localparam logic [1:0] BUSY_TIMEOUT = 2'd3;

    dump_state_t state_q;
    logic [1:0]  tmo_q;
    logic        tx_start_q;
    logic        issue;

    assign issue = ((state_q == IDLE) && req_i) || (state_q == SEND);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            tmo_q      <= 2'd0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE, SEND: begin
                    if (issue) begin
                        if (!tx_active_i) begin
                            tx_start_q <= 1'b1;
                            tmo_q      <= 2'd0;
                            state_q    <= WAIT_BUSY;
                        end else begin
                            state_q <= SEND;
                        end
                    end
                end
                WAIT_BUSY: begin
                    if (tx_active_i || (tmo_q == BUSY_TIMEOUT)) begin
                        state_q <= WAIT_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 2'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (!tx_active_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o      = (state_q == WAIT_IDLE) && !tx_active_i;
    assign tx_start_o = tx_start_q;
    assign state_o    = state_q;

endmodule

// File: rtl/sample_dumper.sv
// Streams the circular sample RAM over uart_tx, oldest sample first, after a capture completes.
// Optional SAMPLE_DUMP_FRAME_EN wraps the data in an AA/offset header and an XOR trailer.
module sample_dumper
    import sampler_pkg::*;
#(
    parameter int SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH,
    parameter int PRE_TRIG     = 2**(SAMPLE_DEPTH-1)
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    activate,
    output logic                    done,
    input  logic [SAMPLE_DEPTH-1:0] offset,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    input  logic [7:0]              mem_rd_data,
    input  logic                    tx_active,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output dump_state_t             dbg_state
);

    localparam int                    LAST_INT   = 2**SAMPLE_DEPTH - 1;
    localparam logic [SAMPLE_DEPTH:0] LAST_COUNT = LAST_INT[SAMPLE_DEPTH:0];
    localparam logic [SAMPLE_DEPTH-1:0] PRE_TRIG_A = PRE_TRIG[SAMPLE_DEPTH-1:0];

    dump_state_t             state_q;
    logic                    activate_q;
    logic                    done_q;
    logic [7:0]              tx_data_q;
    logic [SAMPLE_DEPTH-1:0] mem_addr_q;
    logic [SAMPLE_DEPTH:0]   count_q;
`ifdef SAMPLE_DUMP_FRAME_EN
    logic [SAMPLE_DEPTH-1:0] offset_q;
    logic [7:0]              csum_q;
    frame_phase_t            phase_q;
`endif

    logic        hs_ack;
    dump_state_t hs_state;

    tx_byte_handshake u_hs (
        .clk_i       (clk_50mhz),
        .rst_n_i     (reset),
        .req_i       (state_q == SEND),
        .tx_active_i (tx_active),
        .tx_start_o  (tx_start),
        .ack_o       (hs_ack),
        .state_o     (hs_state)
    );

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            state_q    <= IDLE;
            activate_q <= 1'b0;
            done_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            mem_addr_q <= '0;
            count_q    <= '0;
`ifdef SAMPLE_DUMP_FRAME_EN
            offset_q   <= '0;
            csum_q     <= 8'h00;
            phase_q    <= PH_HDR0;
`endif
        end else begin
            activate_q <= activate;
            case (state_q)
                IDLE: begin
                    if (activate && !activate_q) begin
                        mem_addr_q <= offset + PRE_TRIG_A;
                        count_q    <= '0;
`ifdef SAMPLE_DUMP_FRAME_EN
                        offset_q   <= offset;
                        csum_q     <= 8'h00;
                        phase_q    <= PH_HDR0;
                        state_q    <= HEADER;
`else
                        state_q    <= FETCH;
`endif
                    end
                end
`ifdef SAMPLE_DUMP_FRAME_EN
                HEADER: begin
                    tx_data_q <= (phase_q == PH_HDR0) ? FRAME_BYTE : 8'(offset_q);
                    state_q   <= SEND;
                end
                TRAILER: begin
                    tx_data_q <= csum_q;
                    state_q   <= SEND;
                end
`endif
                FETCH: state_q <= LATCH;
                LATCH: begin
                    tx_data_q <= mem_rd_data;
`ifdef SAMPLE_DUMP_FRAME_EN
                    csum_q    <= csum_q ^ mem_rd_data;
`endif
                    state_q   <= SEND;
                end
                SEND: begin
                    if (hs_ack) begin
`ifdef SAMPLE_DUMP_FRAME_EN
                        if (phase_q == PH_HDR0) begin
                            phase_q <= PH_HDR1;
                            state_q <= HEADER;
                        end else if (phase_q == PH_HDR1) begin
                            phase_q <= PH_DATA;
                            state_q <= FETCH;
                        end else if (phase_q == PH_TRAIL) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else
`endif
                        begin
                            count_q    <= count_q + 1'b1;
                            mem_addr_q <= mem_addr_q + 1'b1;
                            if (count_q == LAST_COUNT) begin
`ifdef SAMPLE_DUMP_FRAME_EN
                                phase_q <= PH_TRAIL;
                                state_q <= TRAILER;
`else
                                done_q  <= 1'b1;
                                state_q <= DONE;
`endif
                            end else begin
                                state_q <= FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!activate) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // While a byte is in flight the handshake's own phase is the more useful view.
    assign dbg_state = ((state_q == SEND) && (hs_state != IDLE)) ? hs_state : state_q;
    assign done      = done_q;
    assign tx_data   = tx_data_q;
    assign mem_addr  = mem_addr_q;

endmodule
